// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter onto a single slave port
// Optional WAIT-state timeout is compiled in with `define ARB_TIMEOUT_EN.
module bus_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   input  logic        m0_write,
   input  logic [1:0]  m0_size,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   input  logic        m1_write,
   input  logic [1:0]  m1_size,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   output logic        s_write,
   output logic [1:0]  s_size,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t      r_state, w_next;
   logic [1:0]  r_grant, w_grant_next;
   logic        r_last_m1, w_last_next;
   logic        w_done, w_timeout, w_active, w_sel1;
   logic [31:0] w_resp;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst)                   r_cnt <= '0;
      else if (r_state == ISSUE) r_cnt <= '0;
      else if (r_state == WAIT)  r_cnt <= r_cnt + CW'(1);
   end

   // r_cnt holds completed WAIT cycles, so TIMEOUT-1 marks the TIMEOUT-th one
   assign w_timeout = (r_state == WAIT) && !s_ready && (r_cnt == CW'(TIMEOUT - 1));
   assign w_resp    = w_timeout ? 32'hDEADBEEF : s_rdata;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT;
   assign w_timeout        = 1'b0;
   assign w_resp           = s_rdata;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_grant   <= 2'b00;
         r_last_m1 <= 1'b1;
      end else begin
         r_state   <= w_next;
         r_grant   <= w_grant_next;
         r_last_m1 <= w_last_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_grant_next = r_grant;
      w_last_next  = r_last_m1;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               w_next = ISSUE;
               if (m0_valid && m1_valid) w_grant_next = r_last_m1 ? 2'b01 : 2'b10;
               else                      w_grant_next = m0_valid ? 2'b01 : 2'b10;
            end
         end
         ISSUE: w_next = WAIT;
         WAIT: begin
            if (s_ready || w_timeout) begin
               w_done       = 1'b1;
               w_next       = IDLE;
               w_grant_next = 2'b00;
               w_last_next  = r_grant[1];
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // All outputs are forced quiet while rst is high, even before the state register clears
   assign w_active = !rst && (r_state != IDLE);
   assign w_sel1   = r_grant[1];
   assign grant    = rst ? 2'b00 : r_grant;

   always_comb begin
      s_valid  = 1'b0;
      s_write  = 1'b0;
      s_size   = 2'b00;
      s_addr   = 32'h0;
      s_wdata  = 32'h0;
      m0_ready = 1'b0;
      m0_rdata = 32'h0;
      m1_ready = 1'b0;
      m1_rdata = 32'h0;
      err      = 1'b0;
      if (w_active) begin
         s_valid = (r_state == ISSUE);
         s_write = w_sel1 ? m1_write : m0_write;
         s_size  = w_sel1 ? m1_size  : m0_size;
         s_addr  = w_sel1 ? m1_addr  : m0_addr;
         s_wdata = w_sel1 ? m1_wdata : m0_wdata;
      end
      if (!rst && w_done) begin
         m0_ready = r_grant[0];
         m1_ready = r_grant[1];
         m0_rdata = r_grant[0] ? w_resp : 32'h0;
         m1_rdata = r_grant[1] ? w_resp : 32'h0;
         err      = w_timeout;
      end
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
// Covers the ARB_TIMEOUT_EN build as well when that macro is defined.
`timescale 1ns/1ps
module tb_bus_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        m0_valid, m0_write, m0_ready;
   logic [1:0]  m0_size;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_valid, m1_write, m1_ready;
   logic [1:0]  m1_size;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        s_valid, s_write, s_ready, err;
   logic [1:0]  s_size, grant;
   logic [31:0] s_addr, s_wdata, s_rdata;

   bus_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_write(m0_write), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_write(m1_write), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_write(s_write), .s_size(s_size), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .err(err)
   );

   typedef struct {
      logic        m1;
      logic        write;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        v0, v1, w0, w1;
      logic [1:0]  z0, z1;
      logic [31:0] a0, a1, d0, d1;
      int          dly;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];

   int   cmp_cnt = 0;
   int   bad_cnt = 0;
   logic last_m1;
   bit   inflight, pend, slave_en, force_rdy, done0, done1;
   int   slave_dly, wcnt;

   function automatic logic [31:0] slave_data(input logic [31:0] a);
      return (a == 32'h4) ? 32'h12345678 : ((a ^ 32'h5A5A_0000) + 32'h11);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit m, input logic w, input logic [1:0] z,
                        input logic [31:0] a, input logic [31:0] d);
      if (!m) begin
         m0_write = w; m0_size = z; m0_addr = a; m0_wdata = d; m0_valid = 1'b1;
      end else begin
         m1_write = w; m1_size = z; m1_addr = a; m1_wdata = d; m1_valid = 1'b1;
      end
   endtask

   task automatic expect_txn(input bit m, input logic w, input logic [1:0] z, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rd, input logic e);
      exp_t x;
      x.m1 = m; x.write = w; x.size = z; x.addr = a; x.wdata = d; x.rdata = rd; x.err = e;
      sb.push_back(x);
   endtask

   task automatic expect_ok(input bit m, input logic w, input logic [1:0] z,
                            input logic [31:0] a, input logic [31:0] d);
      expect_txn(m, w, z, a, d, slave_data(a), 1'b0);
   endtask

   // One clock: slave model drives just after posedge, DUT is sampled and scored at negedge
   task automatic step();
      exp_t e;
      done0 = 0; done1 = 0;
      @(posedge clk); #1;
      s_ready = 1'b0;
      if (pend && slave_en) begin
         if (wcnt == 0) begin s_ready = 1'b1; pend = 0; end
         else wcnt--;
      end
      if (force_rdy) s_ready = 1'b1;
      s_rdata = s_ready ? slave_data(s_addr) : 32'h0;
      @(negedge clk);
      if (s_valid) begin
         if (sb.size() == 0) check("s_valid_unexpected", s_valid, 0);
         else begin
            check("issue_addr",  s_addr,  sb[0].addr);
            check("issue_write", s_write, sb[0].write);
            check("issue_size",  s_size,  sb[0].size);
            check("issue_wdata", s_wdata, sb[0].wdata);
            check("issue_grant", grant,   sb[0].m1 ? 2'b10 : 2'b01);
            inflight = 1; pend = 1; wcnt = slave_dly;
         end
      end else if (inflight) begin
         check("wait_addr",  s_addr, sb[0].addr);
         check("wait_grant", grant,  sb[0].m1 ? 2'b10 : 2'b01);
      end else begin
         check("idle_grant", grant,  2'b00);
         check("idle_addr",  s_addr, 32'h0);
      end
      if (m0_ready || m1_ready) begin
         if (m0_ready && m1_ready) check("ready_both", {m0_ready, m1_ready}, 2'b00);
         if (!inflight) check("ready_unexpected", {m0_ready, m1_ready}, 2'b00);
         else begin
            e = sb.pop_front();
            check("ready_owner", {m1_ready, m0_ready}, e.m1 ? 2'b10 : 2'b01);
            check("ready_rdata", e.m1 ? m1_rdata : m0_rdata, e.rdata);
            check("ready_err",   err, e.err);
            inflight = 0;
         end
         if (m0_ready) begin m0_valid = 1'b0; done0 = 1; end
         if (m1_ready) begin m1_valid = 1'b0; done1 = 1; end
      end else check("err_quiet", err, 1'b0);
      if (!m0_ready) check("m0_rdata_quiet", m0_rdata, 32'h0);
      if (!m1_ready) check("m1_rdata_quiet", m1_rdata, 32'h0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 40) begin step(); n++; end
      check("drain_left", sb.size(), 0);
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0;
      sb.delete(); inflight = 0; pend = 0; force_rdy = 0; slave_en = 1; slave_dly = 0;
      step(); step();
      rst = 1'b0;
      last_m1 = 1'b1;
   endtask

   initial begin
      rst = 1'b1; s_ready = 1'b0; s_rdata = 32'h0;
      m0_valid = 0; m0_write = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
      m1_valid = 0; m1_write = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
      vecs[0] = '{v0:1'b1, v1:1'b0, w0:1'b0, w1:1'b0, z0:2'd2, z1:2'd0,
                  a0:32'h100, a1:32'h0, d0:32'h0, d1:32'h0, dly:0};
      vecs[1] = '{v0:1'b1, v1:1'b1, w0:1'b1, w1:1'b0, z0:2'd1, z1:2'd2,
                  a0:32'h200, a1:32'h300, d0:32'h11112222, d1:32'h0, dly:1};
      vecs[2] = '{v0:1'b1, v1:1'b1, w0:1'b0, w1:1'b1, z0:2'd2, z1:2'd0,
                  a0:32'h204, a1:32'h304, d0:32'h0, d1:32'hCAFEF00D, dly:0};
      vecs[3] = '{v0:1'b0, v1:1'b1, w0:1'b0, w1:1'b1, z0:2'd0, z1:2'd0,
                  a0:32'h0, a1:32'h400, d0:32'h0, d1:32'h0BADF00D, dly:2};
      vecs[4] = '{v0:1'b1, v1:1'b1, w0:1'b1, w1:1'b1, z0:2'd3, z1:2'd1,
                  a0:32'h500, a1:32'h600, d0:32'h55AA55AA, d1:32'hFFFF0000, dly:0};
      vecs[5] = '{v0:1'b1, v1:1'b0, w0:1'b0, w1:1'b0, z0:2'd2, z1:2'd0,
                  a0:32'h700, a1:32'h0, d0:32'h0, d1:32'h0, dly:5};

      do_reset();
      check("rst_svalid", s_valid, 1'b0);
      check("rst_grant",  grant,   2'b00);
      check("rst_ready",  {m0_ready, m1_ready}, 2'b00);
      check("rst_fields", {s_write, s_size, s_wdata}, 35'h0);

      // Single read: s_valid one cycle after request, ready the cycle after that
      drive(0, 1'b0, 2'd2, 32'h4, 32'h0);
      expect_ok(0, 1'b0, 2'd2, 32'h4, 32'h0);
      step();
      check("lat_svalid_c1", s_valid, 1'b1);
      check("lat_grant_c1",  grant,   2'b01);
      step();
      check("lat_ready_c2",  m0_ready, 1'b1);
      check("lat_rdata_c2",  m0_rdata, 32'h12345678);
      check("lat_grant_c2",  grant,    2'b01);
      check("lat_svalid_c2", s_valid,  1'b0);
      step();
      check("lat_grant_c3",  grant,    2'b00);

      // Simultaneous after reset: m0 first; m0 re-requests at once, so m1 then wins the tie
      do_reset();
      drive(0, 1'b0, 2'd2, 32'h10, 32'h0);
      drive(1, 1'b0, 2'd2, 32'h14, 32'h0);
      expect_ok(0, 1'b0, 2'd2, 32'h10, 32'h0);
      expect_ok(1, 1'b0, 2'd2, 32'h14, 32'h0);
      for (int n = 0; n < 20 && !done0; n++) step();
      check("rr_first_done", done0, 1'b1);
      drive(0, 1'b1, 2'd1, 32'h18, 32'h00C0FFEE);
      expect_ok(0, 1'b1, 2'd1, 32'h18, 32'h00C0FFEE);
      drain();

      // m1 write arrives while m0 sits in WAIT behind a slow slave
      slave_dly = 3;
      drive(0, 1'b0, 2'd2, 32'h20, 32'h0);
      expect_ok(0, 1'b0, 2'd2, 32'h20, 32'h0);
      step();
      drive(1, 1'b1, 2'd2, 32'h08, 32'hA5A5A5A5);
      expect_ok(1, 1'b1, 2'd2, 32'h08, 32'hA5A5A5A5);
      drain();

      // Valid withdrawn mid-transaction still completes
      slave_dly = 1;
      drive(0, 1'b0, 2'd0, 32'h24, 32'h0);
      expect_ok(0, 1'b0, 2'd0, 32'h24, 32'h0);
      step();
      m0_valid = 1'b0;
      drain();

      // Stray slave ready while idle is ignored
      force_rdy = 1; step(); force_rdy = 0;
      check("stray_ready", {m0_ready, m1_ready}, 2'b00);
      check("stray_grant", grant, 2'b00);
      step();

      // Reset in WAIT, slave answers in the cycle after reset
      slave_dly = 2;
      drive(0, 1'b0, 2'd2, 32'h28, 32'h0);
      expect_ok(0, 1'b0, 2'd2, 32'h28, 32'h0);
      step(); step();
      rst = 1'b1; m0_valid = 1'b0; sb.delete(); inflight = 0;
      step();
      check("rstwait_outs", {s_valid, m0_ready, m1_ready, err, grant}, 6'h0);
      rst = 1'b0;
      step();
      check("rstwait_noready", {m0_ready, m1_ready}, 2'b00);
      check("rstwait_idle", {s_valid, grant, s_addr}, 35'h0);
      step();

      // Table of request patterns with a round-robin reference model
      do_reset();
      for (int i = 0; i < 6; i++) begin
         slave_dly = vecs[i].dly;
         if (vecs[i].v0) drive(0, vecs[i].w0, vecs[i].z0, vecs[i].a0, vecs[i].d0);
         if (vecs[i].v1) drive(1, vecs[i].w1, vecs[i].z1, vecs[i].a1, vecs[i].d1);
         if (vecs[i].v0 && (!vecs[i].v1 || last_m1))
            expect_ok(0, vecs[i].w0, vecs[i].z0, vecs[i].a0, vecs[i].d0);
         if (vecs[i].v1)
            expect_ok(1, vecs[i].w1, vecs[i].z1, vecs[i].a1, vecs[i].d1);
         if (vecs[i].v0 && vecs[i].v1 && !last_m1)
            expect_ok(0, vecs[i].w0, vecs[i].z0, vecs[i].a0, vecs[i].d0);
         if (!(vecs[i].v0 && vecs[i].v1)) last_m1 = vecs[i].v1;
         drain();
      end

`ifdef ARB_TIMEOUT_EN
      do_reset();
      slave_en = 0;
      drive(0, 1'b0, 2'd2, 32'h30, 32'h0);
      expect_txn(0, 1'b0, 2'd2, 32'h30, 32'h0, 32'hDEADBEEF, 1'b1);
      step();
      begin
         int k = 0;
         while (!done0 && k < 10) begin step(); k++; end
         check("timeout_wait_cycle", k, 4);
      end
      step();
      slave_en = 1; slave_dly = 3;
      drive(0, 1'b0, 2'd2, 32'h34, 32'h0);
      expect_ok(0, 1'b0, 2'd2, 32'h34, 32'h0);
      drain();
`else
      do_reset();
      slave_en = 0;
      drive(0, 1'b0, 2'd2, 32'h30, 32'h0);
      expect_ok(0, 1'b0, 2'd2, 32'h30, 32'h0);
      repeat (100) step();
      check("hang_pending", sb.size(), 1);
      check("hang_grant", grant, 2'b01);
      do_reset();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
      $finish;
   end
endmodule
